// File: rtl/edp_slice_p_if.sv
// Control/data bundle between CRAM/CTL decode and one EDP slice.
interface edp_slice_p_if #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned FM_BLOCKS = 8,
  parameter int unsigned FM_ACS    = 16
);
  localparam int unsigned BLK_W = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1;
  localparam int unsigned ACS_W = (FM_ACS > 1) ? $clog2(FM_ACS) : 1;

  logic [2:0]       ad_sel;
  logic             ad_cin;
  logic [1:0]       ada_sel;
  logic             ada_dis;
  logic [1:0]       adb_sel;
  logic [1:0]       arr_sel;
  logic             arr_load;
  logic             arr_clr;
  logic             arx_load;
  logic             arxr_sel;
  logic             br_load;
  logic             brx_load;
  logic [1:0]       mq_sel;
  logic             mq_sin_l;
  logic             mq_sin_r;
  logic [WIDTH-1:0] cache_data;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] armm;
  logic [WIDTH-1:0] pc;
  logic [BLK_W-1:0] fm_blk;
  logic [ACS_W-1:0] fm_adr;
  logic             fm_write;
  logic             fm_chk_en;
  logic             fm_par_clr;
  logic             ad_to_ebus;

  logic [WIDTH-1:0] ad;
  logic             ad_cry_out;
  logic             ad_cg;
  logic             ad_cp;
  logic             ad_zero;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] arx;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] brx;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] fm_q;
  logic             fm_parity;
  logic             fm_par_err;
  logic [WIDTH-1:0] ebus_d;

  modport master (
    output ad_sel, ad_cin, ada_sel, ada_dis, adb_sel, arr_sel, arr_load, arr_clr,
           arx_load, arxr_sel, br_load, brx_load, mq_sel, mq_sin_l, mq_sin_r,
           cache_data, sh, armm, pc, fm_blk, fm_adr, fm_write, fm_chk_en,
           fm_par_clr, ad_to_ebus,
    input  ad, ad_cry_out, ad_cg, ad_cp, ad_zero, ar, arx, br, brx, mq,
           fm_q, fm_parity, fm_par_err, ebus_d
  );

  modport slave (
    input  ad_sel, ad_cin, ada_sel, ada_dis, adb_sel, arr_sel, arr_load, arr_clr,
           arx_load, arxr_sel, br_load, brx_load, mq_sel, mq_sin_l, mq_sin_r,
           cache_data, sh, armm, pc, fm_blk, fm_adr, fm_write, fm_chk_en,
           fm_par_clr, ad_to_ebus,
    output ad, ad_cry_out, ad_cg, ad_cp, ad_zero, ar, arx, br, brx, mq,
           fm_q, fm_parity, fm_par_err, ebus_d
  );
endinterface

// File: rtl/edp_slice_p.sv
// One WIDTH-bit EDP slice: AR/ARX/BR/BRX/MQ, function adder with group
// lookahead, parity-protected fast memory and registered EBUS driver.
module edp_slice_p #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned FM_BLOCKS = 8,
  parameter int unsigned FM_ACS    = 16
) (
  input  logic         clk,
  input  logic         reset,
  edp_slice_p_if.slave bus
);
  localparam int unsigned FM_DEPTH = FM_BLOCKS * FM_ACS;
  localparam int unsigned IDX_W    = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;

  logic [WIDTH-1:0] ar_q, arx_q, br_q, brx_q, mq_q, fm_q_q, ebus_q;
  logic             fm_par_q, chk_q, par_err_q;

  logic [WIDTH-1:0] a_op, b_op, b_arith, ad_c;
  logic [WIDTH:0]   sum_c, gen_c;
  logic             arith_c, cry_c, cg_c, cp_c;
  logic             fm_bad_c;
  logic [IDX_W-1:0] fm_idx;

  // Parity bit lives in the MSB of each word
  logic [WIDTH:0]   fm_mem [FM_DEPTH];

  assign fm_idx = IDX_W'(bus.fm_blk) * IDX_W'(FM_ACS) + IDX_W'(bus.fm_adr);

  // Operand muxes and function-selectable adder with group carry terms
  always_comb begin
    a_op    = '0;
    b_op    = '0;
    b_arith = '0;
    arith_c = 1'b0;
    ad_c    = '0;
    cry_c   = 1'b0;
    cg_c    = 1'b0;
    cp_c    = 1'b0;
    if (!bus.ada_dis) begin
      case (bus.ada_sel)
        2'd0:    a_op = ar_q;
        2'd1:    a_op = arx_q;
        2'd2:    a_op = mq_q;
        default: a_op = bus.pc;
      endcase
    end
    case (bus.adb_sel)
      2'd0:    b_op = br_q;
      2'd1:    b_op = brx_q;
      2'd2:    b_op = fm_q_q;
      default: b_op = '1;
    endcase
    case (bus.ad_sel)
      3'd0:    begin b_arith = b_op;  arith_c = 1'b1; end
      3'd1:    begin b_arith = ~b_op; arith_c = 1'b1; end
      3'd5:    begin b_arith = '0;    arith_c = 1'b1; end
      default: b_arith = '0;
    endcase
    gen_c = {1'b0, a_op} + {1'b0, b_arith};
    sum_c = gen_c + (WIDTH+1)'(bus.ad_cin);
    case (bus.ad_sel)
      3'd2:    ad_c = a_op & b_op;
      3'd3:    ad_c = a_op | b_op;
      3'd4:    ad_c = a_op ^ b_op;
      3'd6:    ad_c = ~a_op;
      3'd7:    ad_c = '0;
      default: ad_c = sum_c[WIDTH-1:0];
    endcase
    if (arith_c) begin
      cry_c = sum_c[WIDTH];
      cg_c  = gen_c[WIDTH];
      cp_c  = &(a_op ^ b_arith);
    end
  end

  // Data registers; every load samples pre-edge values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_q   <= '0;
      arx_q  <= '0;
      br_q   <= '0;
      brx_q  <= '0;
      mq_q   <= '0;
      ebus_q <= '0;
    end else begin
      if (bus.arr_clr) begin
        ar_q <= '0;
      end else if (bus.arr_load) begin
        case (bus.arr_sel)
          2'd0:    ar_q <= ad_c;
          2'd1:    ar_q <= bus.cache_data;
          2'd2:    ar_q <= bus.sh;
          default: ar_q <= bus.armm;
        endcase
      end
      if (bus.arx_load) arx_q <= bus.arxr_sel ? bus.sh : ad_c;
      if (bus.br_load)  br_q  <= ar_q;
      if (bus.brx_load) brx_q <= ar_q;
      case (bus.mq_sel)
        2'd1:    mq_q <= {mq_q[WIDTH-2:0], bus.mq_sin_l};
        2'd2:    mq_q <= {bus.mq_sin_r, mq_q[WIDTH-1:1]};
        2'd3:    mq_q <= ad_c;
        default: mq_q <= mq_q;
      endcase
      ebus_q <= bus.ad_to_ebus ? ad_c : '0;
    end
  end

  // FM array write (odd parity); array is deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.fm_write) fm_mem[fm_idx] <= {~^ar_q, ar_q};
  end

  // Synchronous FM read (read-before-write) with check-enable pipelined alongside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fm_q_q   <= '0;
      fm_par_q <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      {fm_par_q, fm_q_q} <= fm_mem[fm_idx];
      chk_q              <= bus.fm_chk_en;
    end
  end

  assign fm_bad_c = chk_q && (^{fm_q_q, fm_par_q} == 1'b0);

  // Sticky parity error; a new error beats a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else if (fm_bad_c) begin
      par_err_q <= 1'b1;
    end else if (bus.fm_par_clr) begin
      par_err_q <= 1'b0;
    end
  end

  assign bus.ad         = ad_c;
  assign bus.ad_cry_out = cry_c;
  assign bus.ad_cg      = cg_c;
  assign bus.ad_cp      = cp_c;
  assign bus.ad_zero    = (ad_c == '0);
  assign bus.ar         = ar_q;
  assign bus.arx        = arx_q;
  assign bus.br         = br_q;
  assign bus.brx        = brx_q;
  assign bus.mq         = mq_q;
  assign bus.fm_q       = fm_q_q;
  assign bus.fm_parity  = fm_par_q;
  assign bus.fm_par_err = par_err_q;
  assign bus.ebus_d     = ebus_q;
endmodule

// File: doc/edp_slice_p.md
Name: edp_slice_p

Overview:
- Parametrised EDP (execution data path) slice, generalising the fixed 6-bit EDP slices.
- Holds the AR, ARX, BR, BRX and MQ registers for a WIDTH-bit field, plus a function-selectable adder and group carry-lookahead outputs.
- Includes a block-organised fast memory (FM) with odd parity and a sticky parity-error flag, and a registered EBUS driver.
- Sits between CRAM/CTL decode and the cache/shifter data paths; slices are ganged through `ad_cin`/`ad_cry_out`.

Parameters:
- WIDTH, 6, bits per slice.
- FM_BLOCKS, 8, number of AC blocks.
- FM_ACS, 16, ACs per block.

Ports:
- clk  in  1  EDP clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- ad_sel  in  3  adder function
- ad_cin  in  1  carry into slice LSB
- ada_sel  in  2  A source: 0 AR, 1 ARX, 2 MQ, 3 pc
- ada_dis  in  1  force A to 0
- adb_sel  in  2  B source: 0 BR, 1 BRX, 2 fm_q, 3 all-ones
- arr_sel  in  2  AR input: 0 AD, 1 cache_data, 2 sh, 3 armm
- arr_load, arr_clr, arx_load, arxr_sel, br_load, brx_load  in  1 each  register controls (arxr_sel: 0 AD, 1 sh)
- mq_sel  in  2  0 hold, 1 shift left, 2 shift right, 3 load AD
- mq_sin_l, mq_sin_r  in  1 each  serial-in for left / right shift
- cache_data, sh, armm, pc  in  WIDTH each  data sources
- fm_blk  in  log2(FM_BLOCKS)  AC block
- fm_adr  in  log2(FM_ACS)  AC address
- fm_write  in  1  write AR into FM[fm_blk,fm_adr]
- fm_chk_en  in  1  enable parity check on this read
- fm_par_clr  in  1  clear sticky parity error
- ad_to_ebus  in  1  drive AD onto EBUS next cycle
- ad  out  WIDTH  adder result (combinational)
- ad_cry_out, ad_cg, ad_cp  out  1 each  carry out, group generate, group propagate
- ad_zero  out  1  ad == 0
- ar, arx, br, brx, mq  out  WIDTH each  register contents
- fm_q  out  WIDTH  registered FM read data
- fm_parity  out  1  stored parity bit of fm_q
- fm_par_err  out  1  sticky parity error
- ebus_d  out  WIDTH  registered EBUS data, 0 when not driving

Behaviour:
- Reset (async, high): ar, arx, br, brx, mq, fm_q, ebus_d = 0; fm_parity = 0; fm_par_err = 0; check pipeline cleared. FM array is not reset.
- A operand = `ada_dis ? 0 : mux(ada_sel)`. B operand = `mux(adb_sel)`.
- ad_sel functions:
  - 0: A+B+cin
  - 1: A+~B+cin (subtract when cin=1)
  - 2: A&B
  - 3: A|B
  - 4: A^B
  - 5: A+cin
  - 6: ~A
  - 7: 0
- All sums are modulo 2^WIDTH. ad_cry_out = carry from bit WIDTH-1 for functions 0, 1 and 5; otherwise 0.
- ad_cg / ad_cp use B' = B (fn 0), ~B (fn 1), 0 (fn 5):
  - ad_cg = carry out with cin forced 0.
  - ad_cp = AND over all bits of (A^B').
  - Both are 0 for boolean functions.
  - Invariant for arithmetic functions: ad_cry_out == ad_cg | (ad_cp & ad_cin).
- AR on each clock:
  - arr_clr loads 0; it overrides arr_load.
  - else arr_load loads mux(arr_sel).
  - else AR holds.
- ARX: arx_load loads AD or sh per arxr_sel. BR and BRX load AR when br_load / brx_load are asserted. All loads sample pre-edge values, so AR→BR transfer and a new AR load in the same cycle is legal.
- MQ:
  - left shift: `{mq[WIDTH-2:0], mq_sin_l}`
  - right shift: `{mq_sin_r, mq[WIDTH-1:1]}`
  - load: AD.
- FM:
  - Write on clock when fm_write: data = AR (pre-edge), stored parity = ~^AR (odd).
  - Read is synchronous: fm_q / fm_parity update every clock from the address presented that cycle, 1-cycle latency.
  - Same-address read and write in one cycle returns the old data (read-before-write).
- Parity check:
  - fm_chk_en is registered alongside the read.
  - The cycle after, if the check was enabled and `^{fm_q,fm_parity} == 0`, fm_par_err sets.
  - fm_par_err stays set until reset or fm_par_clr.
  - Simultaneous set and clr: set wins.
  - Unwritten FM locations are undefined; software must write before checked reads.
- EBUS: ebus_d = registered (`ad_to_ebus ? AD : 0`), 1-cycle latency.
- Lookahead group signals are combinational from register outputs and have no clock dependency. Slices cascade by chaining ad_cry_out into the next slice's ad_cin.

Test Plan:
- Reset mid-operation: load AR=0x2A (arr_sel=1), assert reset -> all register outputs, fm_par_err and ebus_d read 0 immediately, without waiting for a clock edge.
- Adder, WIDTH=6: AR=0x3F, BR=0x01, ad_sel=0, cin=0 -> ad=0x00, ad_cry_out=1, ad_cg=1, ad_zero=1. Same operands with ad_sel=1, cin=1 -> ad=0x3E, cry=1. Invariant cry==cg|(cp&cin) checked over random operands.
- MQ: mq=0x25, mq_sel=1, sin_l=1 -> 0x0B. Then mq_sel=2, sin_r=1 -> 0x25.
- FM write then read:
  - Write AR=0x15 to blk 3 / adr 7; read blk 3 / adr 7 with chk_en -> fm_q=0x15 one cycle later, fm_parity=0, no error.
  - Same-cycle write 0x2A and read of that address -> old 0x15, then 0x2A.
- Parity error: force the stored parity bit of a location inverted via backdoor, then do a checked read -> fm_par_err=1 on the following cycle and held. Assert fm_par_clr together with a second bad read -> stays 1. fm_par_clr alone -> 0.
- Controls and EBUS: arr_clr with arr_load both high -> AR=0. ad_to_ebus for one cycle with AD=0x11 -> ebus_d=0x11 for exactly one cycle, then 0.
